pcpi_div_param: RTL

- Parametrised PCPI co-processor for RV32M/RV64M-style DIV, DIVU, REM and REMU.
- Sits on the core's PCPI bus beside the multiplier.
- Generalises the single-bit restoring divider in two ways:
  - XLEN-wide datapath.
  - STEPS_PER_CYCLE quotient bits retired per clock.
- Adds instruction abort, a defined idle output, and an optional operand/result cache.

---
 rtl/pcpi_div_pkg.sv | 34 +++
 rtl/pcpi_div_step.sv | 40 ++++
 rtl/pcpi_div_param.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pcpi_div_pkg.sv
// rtl/pcpi_div_pkg.sv - shared types and decode constants for the PCPI divider
package pcpi_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } op_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic op_e decode_op(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_DIVU: return OP_DIVU;
      FUNCT3_REM:  return OP_REM;
      FUNCT3_REMU: return OP_REMU;
      default:     return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/pcpi_div_step.sv
// rtl/pcpi_div_step.sv - STEPS_PER_CYCLE restoring division steps, MSB first
// Remainder starts as the dividend magnitude; quotient bits are set in place.
module pcpi_div_step #(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1,
  parameter int CW              = 6
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [CW-1:0]   cnt_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  localparam int IW = $clog2(XLEN);

  logic [XLEN-1:0] r;
  logic [XLEN-1:0] q;
  logic [XLEN:0]   diff;
  logic [IW-1:0]   bi;

  always_comb begin
    r    = rem_i;
    q    = quo_i;
    diff = '0;
    bi   = '0;
    for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
      bi   = IW'(int'(cnt_i) * STEPS_PER_CYCLE - 1 - j);
      // (r >> bi) >= div  <=>  div << bi fits under r without losing bits
      diff = {1'b0, r >> bi} - {1'b0, div_i};
      if (!diff[XLEN]) begin
        r     = r - (div_i << bi);
        q[bi] = 1'b1;
      end
    end
    rem_o = r;
    quo_o = q;
  end

endmodule

// File: rtl/pcpi_div_param.sv
// rtl/pcpi_div_param.sv - PCPI DIV/DIVU/REM/REMU co-processor, XLEN wide, STEPS_PER_CYCLE bits/clock
// Optional operand/result cache enabled by PCPI_DIV_RESULT_CACHE_EN.
module pcpi_div_param
  import pcpi_div_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);
  localparam int N  = XLEN / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  state_e          state_q;
  op_e             op_q;
  logic [XLEN-1:0] rem_q, dvs_q, quo_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [CW-1:0]   cnt_q;
  logic            outsign_q;
  logic            wr_q, wait_q, ready_q;
  logic [XLEN-1:0] rd_q;

  logic            insn_match, is_signed, is_rem;
  logic            rs1_neg, rs2_neg, outsign_d;
  logic [XLEN-1:0] abs_rs1, abs_rs2, res_mag;
  logic            unused_insn;

  assign insn_match = pcpi_valid && !ready_q
                   && (pcpi_insn[6:0] == OPCODE_OP)
                   && (pcpi_insn[31:25] == FUNCT7_MULDIV)
                   && pcpi_insn[14];
  assign is_signed  = (op_q == OP_DIV) || (op_q == OP_REM);
  assign is_rem     = (op_q == OP_REM) || (op_q == OP_REMU);
  assign rs1_neg    = is_signed && pcpi_rs1[XLEN-1];
  assign rs2_neg    = is_signed && pcpi_rs2[XLEN-1];
  assign abs_rs1    = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
  assign abs_rs2    = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
  assign outsign_d  = is_rem ? rs1_neg : (rs1_neg ^ rs2_neg);
  assign res_mag    = is_rem ? rem_q : quo_q;
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

`ifdef PCPI_DIV_RESULT_CACHE_EN
  logic            cache_valid_q, cache_wr_q, cache_signed_q, cache_hit;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q, cache_quo_q, cache_rem_q;

  assign cache_hit = cache_valid_q && (cache_rs1_q == pcpi_rs1)
                  && (cache_rs2_q == pcpi_rs2) && (cache_signed_q == is_signed);
`endif

  pcpi_div_step #(
    .XLEN           (XLEN),
    .STEPS_PER_CYCLE(STEPS_PER_CYCLE),
    .CW             (CW)
  ) u_step (
    .rem_i(rem_q),
    .div_i(dvs_q),
    .quo_i(quo_q),
    .cnt_i(cnt_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DIV;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      outsign_q <= 1'b0;
      wr_q      <= 1'b0;
      wait_q    <= 1'b0;
      ready_q   <= 1'b0;
      rd_q      <= '0;
`ifdef PCPI_DIV_RESULT_CACHE_EN
      cache_valid_q  <= 1'b0;
      cache_wr_q     <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
`endif
    end else begin
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (insn_match) begin
            op_q    <= decode_op(pcpi_insn[14:12]);
            wait_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef PCPI_DIV_RESULT_CACHE_EN
          cache_wr_q <= 1'b0;
`endif
          if (!pcpi_valid) begin
            wait_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (pcpi_rs2 == '0) begin
            // Encode the divide-by-zero answer so FINISH needs no special case
            quo_q     <= '1;
            rem_q     <= pcpi_rs1;
            outsign_q <= 1'b0;
            state_q   <= ST_FINISH;
`ifdef PCPI_DIV_RESULT_CACHE_EN
          end else if (cache_hit) begin
            quo_q     <= cache_quo_q;
            rem_q     <= cache_rem_q;
            outsign_q <= outsign_d;
            state_q   <= ST_FINISH;
`endif
          end else begin
            rem_q     <= abs_rs1;
            dvs_q     <= abs_rs2;
            quo_q     <= '0;
            cnt_q     <= CW'(N);
            outsign_q <= outsign_d;
            state_q   <= ST_RUN;
`ifdef PCPI_DIV_RESULT_CACHE_EN
            cache_wr_q <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (!pcpi_valid) begin
            wait_q  <= 1'b0;
            state_q <= ST_IDLE;
`ifdef PCPI_DIV_RESULT_CACHE_EN
            cache_wr_q <= 1'b0;
`endif
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          wr_q    <= 1'b1;
          ready_q <= 1'b1;
          wait_q  <= 1'b0;
          rd_q    <= outsign_q ? -res_mag : res_mag;
          state_q <= ST_IDLE;
`ifdef PCPI_DIV_RESULT_CACHE_EN
          cache_wr_q <= 1'b0;
          if (cache_wr_q) begin
            cache_valid_q  <= 1'b1;
            cache_rs1_q    <= pcpi_rs1;
            cache_rs2_q    <= pcpi_rs2;
            cache_signed_q <= is_signed;
            cache_quo_q    <= quo_q;
            cache_rem_q    <= rem_q;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pcpi_wr    = wr_q;
  assign pcpi_rd    = rd_q;
  assign pcpi_wait  = wait_q;
  assign pcpi_ready = ready_q;

endmodule
